// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32IM pipeline: load-use bubbles,
// taken-branch squashes and multi-cycle MUL/DIV sequencing in EX.
module pipeline_hazard_ctrl #(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [4:0] ID_RS1,
    input  logic [4:0] ID_RS2,
    input  logic       ID_USES_RS1,
    input  logic       ID_USES_RS2,
    input  logic [4:0] EX_RD,
    input  logic       EX_MEM_READ,
    input  logic       EX_IS_MULDIV,
    input  logic       EX_IS_DIV,
    input  logic       BRANCH_TAKEN,
    output logic       PC_WRITE_EN,
    output logic       IFID_WRITE_EN,
    output logic       IDEX_WRITE_EN,
    output logic       BUBBLE_SEL,
    output logic       IFID_FLUSH,
    output logic       EXMEM_BUBBLE,
    output logic       MULDIV_START,
    output logic       MULDIV_BUSY
);

    typedef enum logic [0:0] {StRun, StMdBusy} state_e;

    // The start cycle is itself the first stall, so the counter loads N-1.
    localparam logic [5:0] MulLoad = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DivLoad = 6'(DIV_CYCLES - 1);

    state_e     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       load_use;

    assign load_use = EX_MEM_READ && (EX_RD != 5'd0) &&
                      ((ID_USES_RS1 && (ID_RS1 == EX_RD)) ||
                       (ID_USES_RS2 && (ID_RS2 == EX_RD)));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StRun;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        PC_WRITE_EN   = 1'b1;
        IFID_WRITE_EN = 1'b1;
        IDEX_WRITE_EN = 1'b1;
        BUBBLE_SEL    = 1'b0;
        IFID_FLUSH    = 1'b0;
        EXMEM_BUBBLE  = 1'b0;
        MULDIV_START  = 1'b0;
        MULDIV_BUSY   = 1'b0;

        if (RESET) begin
            state_d       = StRun;
            cnt_d         = 6'd0;
            PC_WRITE_EN   = 1'b0;
            IFID_WRITE_EN = 1'b0;
            IDEX_WRITE_EN = 1'b0;
            BUBBLE_SEL    = 1'b1;
            IFID_FLUSH    = 1'b1;
            EXMEM_BUBBLE  = 1'b1;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (EX_IS_MULDIV) begin
                        MULDIV_START  = 1'b1;
                        PC_WRITE_EN   = 1'b0;
                        IFID_WRITE_EN = 1'b0;
                        IDEX_WRITE_EN = 1'b0;
                        EXMEM_BUBBLE  = 1'b1;
                        state_d       = StMdBusy;
                        cnt_d         = EX_IS_DIV ? DivLoad : MulLoad;
                    end else if (BRANCH_TAKEN) begin
                        // Squash wins over load-use: the ID instruction is discarded anyway.
                        IFID_FLUSH = 1'b1;
                        BUBBLE_SEL = 1'b1;
                    end else if (load_use) begin
                        PC_WRITE_EN   = 1'b0;
                        IFID_WRITE_EN = 1'b0;
                        BUBBLE_SEL    = 1'b1;
                    end
                end
                StMdBusy: begin
                    MULDIV_BUSY = 1'b1;
                    if (cnt_q != 6'd0) begin
                        PC_WRITE_EN   = 1'b0;
                        IFID_WRITE_EN = 1'b0;
                        IDEX_WRITE_EN = 1'b0;
                        EXMEM_BUBBLE  = 1'b1;
                        cnt_d         = cnt_q - 6'd1;
                    end else begin
                        state_d = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: outputs are packed into one byte
// {PC,IFID,IDEX,BUBBLE,FLUSH,EXMEM,START,BUSY} and compared to hand-made constants.
module tb_pipeline_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [4:0] ID_RS1, ID_RS2, EX_RD;
    logic       ID_USES_RS1, ID_USES_RS2, EX_MEM_READ, EX_IS_MULDIV, EX_IS_DIV, BRANCH_TAKEN;
    logic       PC_WRITE_EN, IFID_WRITE_EN, IDEX_WRITE_EN, BUBBLE_SEL;
    logic       IFID_FLUSH, EXMEM_BUBBLE, MULDIV_START, MULDIV_BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [7:0] VRst  = 8'b0001_1100;
    localparam logic [7:0] VRun  = 8'b1110_0000;
    localparam logic [7:0] VLu   = 8'b0011_0000;
    localparam logic [7:0] VBr   = 8'b1111_1000;
    localparam logic [7:0] VMdSt = 8'b0000_0110;
    localparam logic [7:0] VMdBz = 8'b0000_0101;
    localparam logic [7:0] VMdRl = 8'b1110_0001;

    pipeline_hazard_ctrl #(
        .MUL_CYCLES(2),
        .DIV_CYCLES(16)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .ID_RS1       (ID_RS1),
        .ID_RS2       (ID_RS2),
        .ID_USES_RS1  (ID_USES_RS1),
        .ID_USES_RS2  (ID_USES_RS2),
        .EX_RD        (EX_RD),
        .EX_MEM_READ  (EX_MEM_READ),
        .EX_IS_MULDIV (EX_IS_MULDIV),
        .EX_IS_DIV    (EX_IS_DIV),
        .BRANCH_TAKEN (BRANCH_TAKEN),
        .PC_WRITE_EN  (PC_WRITE_EN),
        .IFID_WRITE_EN(IFID_WRITE_EN),
        .IDEX_WRITE_EN(IDEX_WRITE_EN),
        .BUBBLE_SEL   (BUBBLE_SEL),
        .IFID_FLUSH   (IFID_FLUSH),
        .EXMEM_BUBBLE (EXMEM_BUBBLE),
        .MULDIV_START (MULDIV_START),
        .MULDIV_BUSY  (MULDIV_BUSY)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] outs();
        return {PC_WRITE_EN, IFID_WRITE_EN, IDEX_WRITE_EN, BUBBLE_SEL,
                IFID_FLUSH, EXMEM_BUBBLE, MULDIV_START, MULDIV_BUSY};
    endfunction

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Settle combinational outputs, then compare.
    task automatic chk(input string tag, input logic [7:0] exp);
        #1;
        check_eq(tag, outs(), exp);
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ID_RS1 = 5'd0; ID_RS2 = 5'd0; EX_RD = 5'd0;
        ID_USES_RS1 = 1'b0; ID_USES_RS2 = 1'b0; EX_MEM_READ = 1'b0;
        EX_IS_MULDIV = 1'b0; EX_IS_DIV = 1'b0; BRANCH_TAKEN = 1'b0;
    endtask

    task automatic lu_rs2(input logic [4:0] rd, input logic uses);
        idle();
        EX_MEM_READ = 1'b1; EX_RD = rd; ID_RS2 = rd; ID_USES_RS2 = uses;
    endtask

    initial begin
        idle();
        RESET = 1'b1;
        chk("reset_async_start", VRst);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("reset_hold", VRst);
        end
        RESET = 1'b0;
        chk("post_reset_idle", VRun);

        // Load-use hazards
        lu_rs2(5'd5, 1'b1);
        chk("lu_rs2_stall", VLu);
        cyc(); idle();
        chk("lu_cleared", VRun);
        lu_rs2(5'd0, 1'b1);
        chk("lu_rd_x0", VRun);
        lu_rs2(5'd5, 1'b0);
        chk("lu_rs2_unused", VRun);
        idle(); EX_MEM_READ = 1'b1; EX_RD = 5'd9; ID_RS1 = 5'd9; ID_USES_RS1 = 1'b1;
        ID_RS2 = 5'd3; ID_USES_RS2 = 1'b1;
        chk("lu_rs1_stall", VLu);
        EX_MEM_READ = 1'b0;
        chk("no_load_no_stall", VRun);

        // Branch overrides a simultaneous hazard
        lu_rs2(5'd5, 1'b1); BRANCH_TAKEN = 1'b1;
        chk("branch_plus_lu", VBr);
        cyc(); idle();
        chk("after_branch", VRun);

        // MUL: 2 stall cycles then release
        EX_IS_MULDIV = 1'b1; EX_IS_DIV = 1'b0;
        chk("mul_start", VMdSt);
        cyc(); chk("mul_stall2", VMdBz);
        cyc(); chk("mul_release", VMdRl);
        cyc(); idle();
        chk("mul_back_to_run", VRun);

        // DIV with distractors; EX_IS_DIV only matters on the start cycle
        EX_IS_MULDIV = 1'b1; EX_IS_DIV = 1'b1;
        chk("div_start", VMdSt);
        for (int k = 2; k <= 16; k++) begin
            cyc();
            EX_IS_DIV = 1'b0;
            EX_MEM_READ = 1'b1; EX_RD = 5'd7; ID_RS1 = 5'd7; ID_USES_RS1 = 1'b1;
            BRANCH_TAKEN = (k == 5);
            chk($sformatf("div_stall%0d", k), VMdBz);
        end
        cyc(); BRANCH_TAKEN = 1'b0;
        chk("div_release", VMdRl);

        // Back-to-back MUL in EX right after the release
        idle(); EX_IS_MULDIV = 1'b1;
        cyc(); chk("b2b_mul_start", VMdSt);
        cyc(); chk("b2b_mul_stall", VMdBz);
        cyc(); chk("b2b_mul_release", VMdRl);
        cyc(); idle();
        chk("b2b_back_to_run", VRun);

        // Reset in the middle of a DIV
        EX_IS_MULDIV = 1'b1; EX_IS_DIV = 1'b1;
        chk("div2_start", VMdSt);
        for (int k = 2; k <= 7; k++) begin
            cyc();
            chk("div2_stall", VMdBz);
        end
        RESET = 1'b1;
        chk("mid_div_reset_async", VRst);
        cyc(); chk("mid_div_reset_hold", VRst);
        RESET = 1'b0; idle();
        chk("after_mid_reset", VRun);
        cyc(); chk("no_residual_stall", VRun);
        cyc(); chk("no_residual_stall2", VRun);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
